calc_seq_ctrl: RTL and testbench

- Sequencer for the calculator's shared 7-bit combinational adder (external `add` datapath).
- Latches two operands and an opcode on a start pulse, then drives the adder over one or more cycles:
  - ADD: one pass.
  - SUB: two passes (invert, then +1).
  - MUL: WIDTH shift-add passes.
- Registers the result and flags, and signals completion to the calculator top level and display logic.

---
 rtl/calc_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/calc_seq_ctrl.sv
// Sequencer for the calculator's shared WIDTH-bit adder: runs ADD (1 pass),
// SUB (invert then +1) and MUL (WIDTH shift-add passes) and registers result/flags.
module calc_seq_ctrl #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_SUB_INV, S_SUB_INC, S_MUL_STEP, S_DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_r, a_n, b_r, b_n, acc, acc_n, tmp, tmp_n;
  logic [1:0]       op_r, op_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             c1, c1_n, movf, movf_n;
  logic [WIDTH-1:0] alu_x_n, alu_y_n, result_n;
  logic             ovf_n, err_n;
  logic [2*WIDTH-1:0] a_wide;
  logic             spill, bit_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Bits of A pushed past the adder width by the current multiplier shift.
  assign a_wide  = {{WIDTH{1'b0}}, a_r} << cnt;
  assign spill   = |a_wide[2*WIDTH-1:WIDTH];
  assign bit_set = b_r[cnt];

  always_comb begin
    state_n  = state;
    a_n      = a_r;
    b_n      = b_r;
    op_n     = op_r;
    acc_n    = acc;
    tmp_n    = tmp;
    cnt_n    = cnt;
    c1_n     = c1;
    movf_n   = movf;
    alu_x_n  = alu_x;
    alu_y_n  = alu_y;
    result_n = result;
    ovf_n    = ovf;
    err_n    = err;
    case (state)
      S_IDLE: begin
        alu_x_n = '0;
        alu_y_n = '0;
        if (start) begin
          a_n  = a_in;
          b_n  = b_in;
          op_n = op;
          case (op)
            2'b01: begin
              state_n = S_SUB_INV;
              alu_x_n = a_in;
              alu_y_n = ~b_in;
            end
            2'b10: begin
              state_n = S_MUL_STEP;
              acc_n   = '0;
              cnt_n   = '0;
              movf_n  = 1'b0;
              alu_x_n = '0;
              alu_y_n = a_in;
            end
            // Illegal opcode takes the single-pass slot so it shares ADD's latency.
            default: begin
              state_n = S_ADD;
              alu_x_n = a_in;
              alu_y_n = b_in;
            end
          endcase
        end
      end
      S_ADD: begin
        state_n = S_DONE;
        alu_x_n = '0;
        alu_y_n = '0;
        if (op_r == 2'b11) begin
          result_n = '0;
          ovf_n    = 1'b0;
          err_n    = 1'b1;
        end else begin
          result_n = alu_sum;
          ovf_n    = alu_cout;
          err_n    = 1'b0;
        end
      end
      S_SUB_INV: begin
        state_n = S_SUB_INC;
        tmp_n   = alu_sum;
        c1_n    = alu_cout;
        alu_x_n = alu_sum;
        alu_y_n = WIDTH'(1);
      end
      S_SUB_INC: begin
        state_n  = S_DONE;
        result_n = alu_sum;
        ovf_n    = ~(c1 | alu_cout);
        err_n    = 1'b0;
        alu_x_n  = '0;
        alu_y_n  = '0;
      end
      S_MUL_STEP: begin
        acc_n   = bit_set ? alu_sum : acc;
        movf_n  = movf | (bit_set & (alu_cout | spill));
        cnt_n   = cnt + 1'b1;
        alu_x_n = acc_n;
        alu_y_n = a_r << (32'(cnt) + 1);
        if (cnt == CW'(WIDTH-1)) begin
          state_n  = S_DONE;
          result_n = acc_n;
          ovf_n    = movf_n;
          err_n    = 1'b0;
          alu_x_n  = '0;
          alu_y_n  = '0;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        alu_x_n = '0;
        alu_y_n = '0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= '0;
      acc    <= '0;
      tmp    <= '0;
      cnt    <= '0;
      c1     <= 1'b0;
      movf   <= 1'b0;
      alu_x  <= '0;
      alu_y  <= '0;
      result <= '0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else begin
      a_r    <= a_n;
      b_r    <= b_n;
      op_r   <= op_n;
      acc    <= acc_n;
      tmp    <= tmp_n;
      cnt    <= cnt_n;
      c1     <= c1_n;
      movf   <= movf_n;
      alu_x  <= alu_x_n;
      alu_y  <= alu_y_n;
      result <= result_n;
      ovf    <= ovf_n;
      err    <= err_n;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed + random bench for calc_seq_ctrl against an arithmetic reference model.
module tb_calc_seq_ctrl;
  localparam int W = 7;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic [W-1:0] alu_x, alu_y, alu_sum, result;
  logic         alu_cout, busy, done, ovf, err;
  int nchk = 0, nfail = 0;

  always #5 clk = ~clk;

  // External combinational adder.
  assign {alu_cout, alu_sum} = {1'b0, alu_x} + {1'b0, alu_y};

  calc_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .alu_x(alu_x), .alu_y(alu_y), .alu_sum(alu_sum), .alu_cout(alu_cout),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int o, input int a, input int b,
                                output int r, output int ov, output int er, output int lat);
    int full;
    er = 0;
    case (o)
      0: begin full = a + b; r = full % (1 << W); ov = int'(full >= (1 << W)); lat = 2; end
      1: begin r = (a - b + (1 << W)) % (1 << W); ov = int'(a < b); lat = 3; end
      2: begin full = a * b; r = full % (1 << W); ov = int'(full >= (1 << W)); lat = W + 1; end
      default: begin r = 0; ov = 0; er = 1; lat = 2; end
    endcase
  endfunction

  // Issue one operation and check busy/done every cycle until back in IDLE.
  task automatic run_op(input int o, input int a, input int b, input bit disturb, input string tag);
    int er, eo, ee, lat;
    model(o, a, b, er, eo, ee, lat);
    @(negedge clk);
    start = 1'b1; op = 2'(o); a_in = W'(a); b_in = W'(b);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (disturb && k == 2) begin
        start = 1'b1; a_in = W'($urandom); b_in = W'($urandom); op = 2'($urandom);
      end
      if (disturb && k == 3) start = 1'b0;
      chk({tag, ".busy"}, 32'(busy), 32'(k <= lat));
      chk({tag, ".done"}, 32'(done), 32'(k == lat));
      if (k >= lat) begin
        chk({tag, ".result"}, 32'(result), 32'(er));
        chk({tag, ".ovf"},    32'(ovf),    32'(eo));
        chk({tag, ".err"},    32'(err),    32'(ee));
      end
      if (k == lat + 1) begin
        chk({tag, ".idle_x"}, 32'(alu_x), 32'd0);
        chk({tag, ".idle_y"}, 32'(alu_y), 32'd0);
      end
    end
  endtask

  initial begin
    // Reset state.
    #2;
    chk("rst.busy", 32'(busy), 0);   chk("rst.done", 32'(done), 0);
    chk("rst.result", 32'(result), 0); chk("rst.ovf", 32'(ovf), 0);
    chk("rst.err", 32'(err), 0);     chk("rst.alu_x", 32'(alu_x), 0);
    chk("rst.alu_y", 32'(alu_y), 0);
    @(negedge clk); rst_n = 1'b1;

    run_op(0, 25, 30, 0, "add_25_30");
    run_op(0, 100, 50, 0, "add_ovf");
    run_op(1, 50, 20, 0, "sub_50_20");
    run_op(1, 5, 9, 0, "sub_borrow");
    run_op(1, 0, 0, 0, "sub_0_0");
    run_op(2, 11, 11, 0, "mul_11_11");
    run_op(2, 12, 11, 0, "mul_12_11");
    run_op(2, 64, 2, 0, "mul_64_2");
    run_op(2, 127, 1, 0, "mul_127_1");
    run_op(2, 9, 13, 1, "mul_disturb");
    run_op(3, 17, 4, 0, "illegal");
    run_op(0, 127, 127, 0, "add_max");
    run_op(2, 0, 127, 0, "mul_zero");

    for (int i = 0; i < 16; i++) begin
      int o, a, b;
      o = int'($urandom_range(0, 3));
      a = int'($urandom_range(0, (1 << W) - 1));
      b = int'($urandom_range(0, (1 << W) - 1));
      run_op(o, a, b, bit'(o == 2), $sformatf("rnd%0d_op%0d_%0d_%0d", i, o, a, b));
    end

    // Leave a nonzero result registered, then abort a MUL at count=3.
    run_op(2, 127, 1, 0, "pre_abort");
    @(negedge clk);
    start = 1'b1; op = 2'b10; a_in = W'(100); b_in = W'(100);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 32'(busy), 0);   chk("abort.done", 32'(done), 0);
    chk("abort.result", 32'(result), 0); chk("abort.ovf", 32'(ovf), 0);
    chk("abort.err", 32'(err), 0);     chk("abort.alu_x", 32'(alu_x), 0);
    chk("abort.alu_y", 32'(alu_y), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort.nodone", 32'(done), 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_abort.nodone", 32'(done), 0);
      chk("post_abort.idle", 32'(busy), 0);
    end
    run_op(0, 1, 1, 0, "add_1_1");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
